axis_arb_mux: RTL and testbench
===============================

Name: axis_arb_mux

Overview:
- Frame-granular AXI4-Stream arbitrating multiplexer.
- Merges S_COUNT independent input streams onto one output, using round-robin arbitration at frame boundaries.
- Sits downstream of the per-port processing paths fed by the stream demultiplexer, and recombines traffic toward the shared UDP/IP TX path.
- Once granted, an input holds the output until its tlast beat is accepted, so frames never interleave.

Parameters:
- S_COUNT, 4, number of input streams (≥2)
- DATA_WIDTH, 8, tdata width per stream
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is all ones
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
- ID_ENABLE, 0, propagate tid; when 0, m_axis_tid is 0
- ID_WIDTH, 8, tid width
- DEST_ENABLE, 0, propagate tdest; when 0, m_axis_tdest is 0
- DEST_WIDTH, 8, tdest width
- USER_ENABLE, 1, propagate tuser; when 0, m_axis_tuser is 0
- USER_WIDTH, 1, tuser width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data, port i at slice i
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  input keep
- s_axis_tvalid  in  S_COUNT  input valid
- s_axis_tready  out  S_COUNT  input ready
- s_axis_tlast  in  S_COUNT  input last
- s_axis_tid  in  S_COUNT*ID_WIDTH  input id
- s_axis_tdest  in  S_COUNT*DEST_WIDTH  input dest
- s_axis_tuser  in  S_COUNT*USER_WIDTH  input user
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output keep
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- m_axis_tid  out  ID_WIDTH  output id
- m_axis_tdest  out  DEST_WIDTH  output dest
- m_axis_tuser  out  USER_WIDTH  output user
- grant_valid  out  1  a port currently holds the output
- grant_index  out  $clog2(S_COUNT)  index of the granted port

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst. Polarity and synchronicity are fixed.
- Reset values:
  - m_axis_tvalid=0, s_axis_tready=0, grant_valid=0, grant_index=0.
  - Internal last_grant=S_COUNT-1, so port 0 has first priority.
  - Skid (temp) valid=0.
  - Data registers are not reset.
- Arbiter states:
  - IDLE: no grant. If any s_axis_tvalid is set, grant the first requesting port searching upward from (last_grant+1) mod S_COUNT, with wrap-around. Go to ACTIVE next cycle, set grant_valid=1, grant_index=winner, last_grant=winner.
  - ACTIVE: s_axis_tready = onehot(grant_index) & internal ready. All ungranted ports see ready=0.
  - ACTIVE to IDLE: on an accepted beat (granted tvalid & tready) with tlast=1. The new arbitration is evaluated in that same IDLE cycle, so there is exactly one bubble cycle between frames.
  - Requests that drop tvalid while ungranted are simply not considered; there is no request latching.
  - A granted port that deasserts tvalid mid-frame keeps the grant. There is no timeout.
- Output datapath:
  - Registered output with a 2-entry skid (output reg + temp reg), giving full throughput.
  - Input-to-output latency is 1 cycle.
  - Internal ready is registered from an early term: (m_axis_tready & m_axis_tvalid) | (!temp_valid & (!m_axis_tvalid | !int_valid)).
  - Beats are never dropped or duplicated under any m_axis_tready pattern.
  - m_axis_tvalid must not deassert without a transfer.
- Sideband: tkeep, tid, tdest and tuser follow the same ENABLE rules as tdata and are carried alongside it. The granted port's sideband travels with its data.
- Single-beat frame (tlast on first beat): grant is taken, the beat is accepted, and the block returns to IDLE the following cycle.
- Reset mid-frame: everything returns to reset state on the next edge. Partial frames in flight are discarded. After reset, arbitration restarts from port 0.
- Simultaneous requests from all ports with continuous frames: strict rotation 0,1,2,3,0,…
- Widths: grant_index is $clog2(S_COUNT) wide. The round-robin search uses modulo S_COUNT, including for non-power-of-2 S_COUNT.

Decomposition:
- No shared package is needed. Local parameter CL_S_COUNT = $clog2(S_COUNT).
- One sub-module is natural: arbiter_rr (PORTS parameter). Inputs: request vector, acknowledge (tlast transfer). Outputs: grant one-hot, grant_valid, grant_encoded.
- The mux and skid output stay in the top module.

Test Plan:
- Port 0 alone sends a 5-byte frame 0x01..0x05 with m_axis_tready=1 -> output 0x01..0x05, tlast only on 0x05, first output 1 cycle after the first accepted input, grant_index=0.
- Ports 0 and 2 assert tvalid in the same cycle after reset, 3-beat frames each -> port 0's frame, then 1 bubble cycle, then port 2's frame; no interleaving; s_axis_tready[2]=0 throughout port 0's frame.
- All 4 ports continuously offer 2-beat frames, 16 frames total -> grant order 0,1,2,3 repeated 4 times; each port gets 4 frames.
- Port 1 sends 8 beats while m_axis_tready toggles 1,0,0,1,1,0,… -> all 8 beats out in order, none lost or duplicated, m_axis_tvalid held stable while stalled.
- rst asserted for 1 cycle after beat 3 of a 6-beat frame on port 3 -> next cycle m_axis_tvalid=0, grant_valid=0; a subsequent port 3 frame and port 0 frame offered together -> port 0 granted first.
- Port 2 sends three back-to-back single-beat frames (tlast=1), tuser=1 on the second -> three output beats each with tlast=1, tuser pattern 0,1,0, one bubble cycle between beats.

Source files
------------

// File: rtl/axis_arb_mux_pkg.sv
// axis_arb_mux_pkg: shared types for the frame-granular arbitrating stream mux
package axis_arb_mux_pkg;
  typedef enum logic {ARB_IDLE, ARB_ACTIVE} arb_state_t;
endpackage

// File: rtl/axis_arb_mux_arbiter_rr.sv
// arbiter_rr: round-robin arbiter that holds a grant until the frame is acknowledged
module arbiter_rr
  import axis_arb_mux_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int CW    = $clog2(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic             acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [CW-1:0]    grant_encoded
);
  arb_state_t state, state_next;
  logic [CW-1:0] enc_next, last, last_next, winner;
  always_comb begin
    winner = '0;
    // descending scan so the nearest requester above last wins
    for (int i = PORTS; i >= 1; i--)
      if (request[(int'(last) + i) % PORTS]) winner = CW'((int'(last) + i) % PORTS);
    state_next = state;
    enc_next = grant_encoded;
    last_next = last;
    if (state == ARB_IDLE && |request) begin
      state_next = ARB_ACTIVE;
      enc_next = winner;
      last_next = winner;
    end else if (state == ARB_ACTIVE && acknowledge) begin
      state_next = ARB_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant_encoded <= '0;
      last <= CW'(PORTS - 1);
    end else begin
      state <= state_next;
      grant_encoded <= enc_next;
      last <= last_next;
    end
  end
  assign grant_valid = state == ARB_ACTIVE;
  assign grant = grant_valid ? PORTS'(1) << grant_encoded : '0;
endmodule

// File: rtl/axis_arb_mux.sv
// axis_arb_mux: merges S_COUNT AXI4-Stream inputs onto one output with frame-level round-robin
module axis_arb_mux
  import axis_arb_mux_pkg::*;
#(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index
);
  localparam int CL_S_COUNT = $clog2(S_COUNT);
  localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  logic [S_COUNT-1:0] grant;
  logic int_ready, int_ready_early, int_valid, ack;
  logic m_valid, m_valid_next, temp_valid, temp_valid_next;
  logic store_int, store_temp, temp_to_out;
  logic [BW-1:0] int_beat, m_beat, temp_beat;
  logic [KEEP_WIDTH-1:0] m_keep;
  logic [ID_WIDTH-1:0] m_id;
  logic [DEST_WIDTH-1:0] m_dest;
  logic [USER_WIDTH-1:0] m_user;
  logic [CL_S_COUNT-1:0] gi;
  arbiter_rr #(.PORTS(S_COUNT)) u_arb (
    .clk(clk),
    .rst(rst),
    .request(s_axis_tvalid),
    .acknowledge(ack),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_encoded(gi)
  );
  assign grant_index = gi;
  assign s_axis_tready = grant & {S_COUNT{int_ready}};
  assign ack = s_axis_tvalid[gi] & s_axis_tready[gi] & s_axis_tlast[gi];
  assign int_valid = grant_valid & s_axis_tvalid[gi] & int_ready;
  assign int_beat = {s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH], s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH],
                     s_axis_tlast[gi], s_axis_tid[gi*ID_WIDTH +: ID_WIDTH],
                     s_axis_tdest[gi*DEST_WIDTH +: DEST_WIDTH], s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH]};
  // ready is registered, so the temp slot absorbs the one beat that lands after a stall
  assign int_ready_early = (m_axis_tready & m_valid) | (!temp_valid & (!m_valid | !int_valid));
  always_comb begin
    m_valid_next = m_valid;
    temp_valid_next = temp_valid;
    store_int = 1'b0;
    store_temp = 1'b0;
    temp_to_out = 1'b0;
    if (int_ready) begin
      if (m_axis_tready || !m_valid) begin
        m_valid_next = int_valid;
        store_int = 1'b1;
      end else begin
        temp_valid_next = int_valid;
        store_temp = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_valid_next = temp_valid;
      temp_valid_next = 1'b0;
      temp_to_out = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      temp_valid <= 1'b0;
      int_ready <= 1'b0;
    end else begin
      m_valid <= m_valid_next;
      temp_valid <= temp_valid_next;
      int_ready <= int_ready_early;
    end
  end
  always_ff @(posedge clk) begin
    if (store_int) m_beat <= int_beat;
    else if (temp_to_out) m_beat <= temp_beat;
    if (store_temp) temp_beat <= int_beat;
  end
  assign {m_axis_tdata, m_keep, m_axis_tlast, m_id, m_dest, m_user} = m_beat;
  assign m_axis_tvalid = m_valid;
  assign m_axis_tkeep = KEEP_ENABLE != 0 ? m_keep : '1;
  assign m_axis_tid = ID_ENABLE != 0 ? m_id : '0;
  assign m_axis_tdest = DEST_ENABLE != 0 ? m_dest : '0;
  assign m_axis_tuser = USER_ENABLE != 0 ? m_user : '0;
endmodule

// File: tb/tb_axis_arb_mux.sv
// tb_axis_arb_mux: randomized scenario bench with a frame-level round-robin reference model
module tb_axis_arb_mux;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [S*8-1:0] s_axis_tdata;
  logic [S-1:0] s_axis_tkeep, s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [S*8-1:0] s_axis_tid, s_axis_tdest;
  logic [7:0] m_axis_tdata, m_axis_tid, m_axis_tdest;
  logic [0:0] m_axis_tkeep, m_axis_tuser;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, grant_valid;
  logic [1:0] grant_index;

  axis_arb_mux dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  always #5 clk = ~clk;

  // per-port source queues, beat = {user, last, data}
  logic [9:0] mem [S][128];
  int head [S];
  int tail [S];
  logic [9:0] got_q [$];
  int got_cyc [$];
  logic [9:0] exp_q [$];
  int cyc, tests, fails;
  logic [S-1:0] sn_fire, sn_tready;
  logic sn_mvalid, sn_mready, sn_gv;
  logic [1:0] sn_gi;
  logic [9:0] sn_beat;
  int sn_cyc;

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      s_axis_tvalid[i] = head[i] < tail[i];
      s_axis_tdata[i*8 +: 8] = mem[i][head[i]][7:0];
      s_axis_tlast[i] = mem[i][head[i]][8];
      s_axis_tuser[i] = mem[i][head[i]][9];
    end
  endtask

  task automatic push_beat(input int p, input logic [7:0] d, input logic l, input logic u);
    mem[p][tail[p]] = {u, l, d};
    tail[p]++;
  endtask

  task automatic step();
    @(negedge clk);
    sn_fire = s_axis_tvalid & s_axis_tready;
    sn_tready = s_axis_tready;
    sn_mvalid = m_axis_tvalid;
    sn_mready = m_axis_tready;
    sn_gv = grant_valid;
    sn_gi = grant_index;
    sn_beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    sn_cyc = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(sn_beat);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < S; i++) if (sn_fire[i]) head[i]++;
    drive();
  endtask

  task automatic clear_ports();
    for (int i = 0; i < S; i++) begin
      head[i] = 0;
      tail[i] = 0;
      for (int k = 0; k < 128; k++) mem[i][k] = '0;
    end
    drive();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_axis_tready = 1'b1;
    clear_ports();
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    got_cyc.delete();
  endtask

  // frame-level model: all queued frames present at once, served whole in round-robin order
  task automatic build_expected(input int start);
    int h [S];
    int p, ptr;
    bit done;
    for (int i = 0; i < S; i++) h[i] = head[i];
    exp_q.delete();
    ptr = start;
    for (int n = 0; n < 64; n++) begin
      p = -1;
      for (int k = S - 1; k >= 0; k--) if (h[(ptr + k) % S] < tail[(ptr + k) % S]) p = (ptr + k) % S;
      if (p < 0) break;
      done = 1'b0;
      while (!done && h[p] < tail[p]) begin
        exp_q.push_back(mem[p][h[p]]);
        done = mem[p][h[p]][8];
        h[p]++;
      end
      ptr = (p + 1) % S;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_ports();
    for (int i = 0; i < S; i++) push_beat(i, 8'(8'hA0 + i), 1'b1, 1'b0);
    drive();
    step();
    step();
    tests += 4;
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    if (s_axis_tready !== 4'b0) begin fails++; $display("FAIL reset_tready: got %b expected 0000", s_axis_tready); end
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL reset_grant_valid: got %b expected 0", grant_valid); end
    if (grant_index !== 2'd0) begin fails++; $display("FAIL reset_grant_index: got %0d expected 0", grant_index); end
  endtask

  task automatic test_single_port();
    int first_in;
    logic gv;
    logic [1:0] gi;
    apply_reset();
    for (int d = 1; d <= 5; d++) push_beat(0, 8'(d), d == 5, 1'b0);
    build_expected(0);
    drive();
    first_in = -1;
    gv = 1'b0;
    gi = 2'd3;
    for (int c = 0; c < 60 && got_q.size() < 5; c++) begin
      step();
      if (sn_fire[0] && first_in < 0) begin first_in = sn_cyc; gv = sn_gv; gi = sn_gi; end
    end
    tests++;
    if (got_q.size() != 5) begin fails++; $display("FAIL single_count: got %0d expected 5", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL single_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
    end
    tests += 2;
    if (got_q.size() == 0 || got_cyc[0] - first_in != 1) begin
      fails++; $display("FAIL single_latency: got %0d expected 1", got_q.size() == 0 ? -1 : got_cyc[0] - first_in);
    end
    if (!gv || gi !== 2'd0) begin fails++; $display("FAIL single_grant: got valid=%b index=%0d expected 1/0", gv, gi); end
  endtask

  task automatic test_two_ports();
    int viol;
    bit busy0;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      push_beat(0, 8'(8'h00 + k), k == 2, 1'b0);
      push_beat(2, 8'(8'h20 + k), k == 2, 1'b1);
    end
    build_expected(0);
    drive();
    viol = 0;
    for (int c = 0; c < 80 && got_q.size() < 6; c++) begin
      busy0 = head[0] < tail[0];
      step();
      if (busy0 && sn_tready[2]) viol++;
    end
    tests++;
    if (got_q.size() != 6) begin fails++; $display("FAIL two_count: got %0d expected 6", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL two_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
    end
    tests += 2;
    if (got_q.size() < 4 || got_cyc[3] - got_cyc[2] != 2) begin
      fails++; $display("FAIL two_bubble: got gap %0d expected 2", got_q.size() < 4 ? -1 : got_cyc[3] - got_cyc[2]);
    end
    if (viol != 0) begin fails++; $display("FAIL two_ready2: got %0d cycles expected 0", viol); end
  endtask

  task automatic test_round_robin();
    int per_port [S];
    int nfr;
    apply_reset();
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < S; p++)
        for (int b = 0; b < 2; b++)
          push_beat(p, {2'(p), 2'(f), 1'(b), 3'($urandom)}, b == 1, 1'($urandom));
    build_expected(0);
    drive();
    for (int c = 0; c < 600 && got_q.size() < 32; c++) begin
      m_axis_tready = $urandom_range(0, 3) != 0;
      step();
    end
    m_axis_tready = 1'b1;
    tests++;
    if (got_q.size() != 32) begin fails++; $display("FAIL rr_count: got %0d expected 32", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL rr_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
    end
    for (int p = 0; p < S; p++) per_port[p] = 0;
    nfr = 0;
    for (int k = 0; k < got_q.size(); k++)
      if (got_q[k][8]) begin
        tests++;
        if (int'(got_q[k][7:6]) != nfr % S) begin
          fails++; $display("FAIL rr_order%0d: got port %0d expected %0d", nfr, got_q[k][7:6], nfr % S);
        end
        per_port[got_q[k][7:6]]++;
        nfr++;
      end
    for (int p = 0; p < S; p++) begin
      tests++;
      if (per_port[p] != 4) begin fails++; $display("FAIL rr_share%0d: got %0d expected 4", p, per_port[p]); end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat = 6'b011001;
    logic prev_stall;
    logic [9:0] prev_beat;
    int stalls, bad;
    apply_reset();
    for (int k = 0; k < 8; k++) push_beat(1, {1'b0, 3'(k), 4'($urandom)}, k == 7, 1'($urandom));
    build_expected(0);
    drive();
    prev_stall = 1'b0;
    prev_beat = '0;
    stalls = 0;
    bad = 0;
    for (int c = 0; c < 120 && got_q.size() < 8; c++) begin
      m_axis_tready = pat[c % 6];
      step();
      if (prev_stall) begin
        stalls++;
        if (!sn_mvalid || sn_beat !== prev_beat) bad++;
      end
      prev_stall = sn_mvalid && !sn_mready;
      prev_beat = sn_beat;
    end
    m_axis_tready = 1'b1;
    tests++;
    if (got_q.size() != 8) begin fails++; $display("FAIL bp_count: got %0d expected 8", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL bp_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
    end
    tests += 2;
    if (bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", bad); end
    if (stalls == 0) begin fails++; $display("FAIL bp_stalls: got 0 stalled cycles expected >0"); end
  endtask

  task automatic test_reset_mid();
    int acc;
    apply_reset();
    for (int k = 0; k < 6; k++) push_beat(3, 8'(8'h30 + k), k == 5, 1'b0);
    drive();
    acc = 0;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      step();
      if (sn_fire[3]) acc++;
    end
    tests++;
    if (acc != 3) begin fails++; $display("FAIL rstmid_accept: got %0d expected 3", acc); end
    rst = 1'b1;
    clear_ports();
    step();
    rst = 1'b0;
    tests += 3;
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid: got %b expected 0", m_axis_tvalid); end
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL rstmid_grant: got %b expected 0", grant_valid); end
    if (s_axis_tready !== 4'b0) begin fails++; $display("FAIL rstmid_tready: got %b expected 0000", s_axis_tready); end
    got_q.delete();
    got_cyc.delete();
    push_beat(3, 8'h38, 1'b0, 1'b0);
    push_beat(3, 8'h39, 1'b1, 1'b1);
    push_beat(0, 8'h08, 1'b0, 1'b1);
    push_beat(0, 8'h09, 1'b1, 1'b0);
    build_expected(0);
    drive();
    for (int c = 0; c < 60 && got_q.size() < 4; c++) step();
    tests++;
    if (got_q.size() != 4) begin fails++; $display("FAIL rstmid_count: got %0d expected 4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL rstmid_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_single_beat();
    apply_reset();
    push_beat(2, 8'h21, 1'b1, 1'b0);
    push_beat(2, 8'h22, 1'b1, 1'b1);
    push_beat(2, 8'h23, 1'b1, 1'b0);
    build_expected(0);
    drive();
    for (int c = 0; c < 60 && got_q.size() < 3; c++) step();
    tests++;
    if (got_q.size() != 3) begin fails++; $display("FAIL sb_count: got %0d expected 3", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL sb_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
    end
    for (int k = 1; k < got_q.size(); k++) begin
      tests++;
      if (got_cyc[k] - got_cyc[k-1] != 2) begin
        fails++; $display("FAIL sb_gap%0d: got %0d expected 2", k, got_cyc[k] - got_cyc[k-1]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    m_axis_tready = 1'b1;
    s_axis_tkeep = '1;
    s_axis_tid = '0;
    s_axis_tdest = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    s_axis_tuser = '0;
    test_reset();
    test_single_port();
    test_two_ports();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
